// File: rtl/blink_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : blink_driver_if
// Description : Request/strobe inputs and pulse/status outputs of
//               blink_driver, bundled as one port.
//               master : drives tick/req, observes led/busy/pending/overflow
//               slave  : the blink_driver side
// Ports       : tick, req (master -> slave)
//               led, busy, pending[PEND_W], overflow (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface blink_driver_if #(
    parameter int PEND_W = 3
);
    logic              tick;
    logic              req;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output tick,
        output req,
        input  led,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  tick,
        input  req,
        output led,
        output busy,
        output pending,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/blink_driver.sv
`default_nettype none
// ============================================================================
// Module      : blink_driver
// Description : Turns single-cycle event requests into human-visible pulses.
//               Each pulse is held high for ON_TICKS tick strobes and is
//               followed by a low gap of OFF_TICKS strobes. Requests that
//               arrive during a pulse are queued as a count and replayed.
//               Requests beyond the queue capacity are dropped, and overflow
//               is raised for one cycle.
// Ports       : clk        system clock
//               rst_async  asynchronous active-high reset
//               bus        blink_driver_if.slave
//                          (tick, req, led, busy, pending, overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module blink_driver #(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4,
    parameter int PEND_W    = 3
) (
    input  logic          clk,
    input  logic          rst_async,
    blink_driver_if.slave bus
);

    // Tick counter must hold max(ON_TICKS, OFF_TICKS)-1.
    localparam int c_TMAX = ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) - 1;
    localparam int c_TW   = (c_TMAX > 0) ? $clog2(c_TMAX + 1) : 1;

    localparam logic [c_TW-1:0]   c_ON_LAST  = c_TW'(ON_TICKS - 1);
    localparam logic [c_TW-1:0]   c_OFF_LAST = c_TW'(OFF_TICKS - 1);
    localparam logic [c_TW-1:0]   c_TCNT_ONE = c_TW'(1);
    localparam logic [PEND_W-1:0] c_PEND_MAX = '1;
    localparam logic [PEND_W-1:0] c_PEND_ONE = PEND_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ON   = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [1:0]        r_state;
    logic [c_TW-1:0]   r_tcnt;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;

    logic [1:0]        w_state_nxt;
    logic [c_TW-1:0]   w_tcnt_nxt;
    logic [PEND_W-1:0] w_pending_nxt;
    logic              w_overflow_nxt;
    logic              w_dequeue;

    // A queued request starts its pulse from IDLE only; this is what forces
    // exactly one IDLE cycle between back-to-back pulses.
    assign w_dequeue = (r_state == c_IDLE) && (r_pending != '0);

    // Pulse sequencer: ticks are counted only in ON and GAP.
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        case (r_state)
            c_IDLE: begin
                if (w_dequeue) begin
                    w_state_nxt = c_ON;
                    w_tcnt_nxt  = '0;
                end
            end
            c_ON: begin
                if (bus.tick) begin
                    if (r_tcnt == c_ON_LAST) begin
                        w_state_nxt = c_GAP;
                        w_tcnt_nxt  = '0;
                    end else begin
                        w_tcnt_nxt  = r_tcnt + c_TCNT_ONE;
                    end
                end
            end
            c_GAP: begin
                if (bus.tick) begin
                    if (r_tcnt == c_OFF_LAST) begin
                        w_state_nxt = c_IDLE;
                        w_tcnt_nxt  = '0;
                    end else begin
                        w_tcnt_nxt  = r_tcnt + c_TCNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_tcnt_nxt  = '0;
            end
        endcase
    end

    // Request accounting. A request coinciding with a dequeue simply takes
    // the dequeued slot, so it can never overflow even when the count is full.
    always_comb begin
        w_pending_nxt  = r_pending;
        w_overflow_nxt = 1'b0;
        if (bus.req && !w_dequeue) begin
            if (r_pending != c_PEND_MAX) begin
                w_pending_nxt = r_pending + c_PEND_ONE;
            end else begin
                w_overflow_nxt = 1'b1;
            end
        end else if (!bus.req && w_dequeue) begin
            w_pending_nxt = r_pending - c_PEND_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state    <= c_IDLE;
            r_tcnt     <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Outputs decode registers only, so led cannot glitch.
    assign bus.led      = (r_state == c_ON);
    assign bus.busy     = (r_state != c_IDLE) || (r_pending != '0);
    assign bus.pending  = r_pending;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/blink_driver.md
# blink_driver

Output-side companion to the input debouncer: it turns single-cycle event requests into clean, human-visible pulses on an output pin (LED or buzzer). Each pulse has a guaranteed minimum on-time and off-gap, measured in the shared slow `tick` strobe. Requests that arrive while a pulse is in progress are counted and replayed in order. Requests beyond the pending capacity are dropped and flagged.

## Interface
Parameters:
- ON_TICKS, default 4: number of `tick` strobes for which the output is held high per event; ≥1.
- OFF_TICKS, default 4: number of `tick` strobes for which the output is held low after each pulse before the next pulse may start; ≥1.
- PEND_W, default 3: width of the pending-request counter; capacity is 2^PEND_W−1.

Ports:
- clk  in  1  system clock.
- rst_async  in  1  reset, asynchronous, active-high.
- tick  in  1  single-cycle timebase strobe, several ms period, synchronous to clk.
- req  in  1  single-cycle event request, synchronous to clk.
- led  out  1  driven output pulse.
- busy  out  1  high while a pulse or gap is in progress or any request is pending.
- pending  out  PEND_W  count of accepted requests not yet started.
- overflow  out  1  one-cycle pulse when a request is dropped.

## Operation
- The block uses three states, encoded in 2 bits:
  - IDLE: `led` is 0.
  - ON: `led` is 1.
  - GAP: `led` is 0.
- `led` = (state == ON), decoded directly from the state register, so it is glitch-free.
- Tick counter `tcnt` is sized to hold max(ON_TICKS, OFF_TICKS)−1. It counts only `tick` strobes seen while in ON or GAP.
- IDLE:
  - If `pending` ≠ 0: go to ON, decrement `pending` (dequeue), clear `tcnt`.
  - `tick` is ignored in IDLE.
- ON:
  - On `tick` with `tcnt` == ON_TICKS−1: go to GAP and clear `tcnt`.
  - On any other `tick`: `tcnt`+1.
- GAP:
  - On `tick` with `tcnt` == OFF_TICKS−1: go to IDLE and clear `tcnt`.
  - On any other `tick`: `tcnt`+1.
- Request accounting is applied every cycle, in every state:
  - req and no dequeue: `pending`+1 if below 2^PEND_W−1. If `pending` is already at the maximum, the request is dropped and `overflow` goes high in the next cycle.
  - req and dequeue in the same cycle: `pending` is unchanged and there is no overflow, even when `pending` is at the maximum.
  - dequeue only: `pending`−1.
- `busy` = (state ≠ IDLE) or (`pending` ≠ 0), combinational from registers.
- Reset is asynchronous and takes effect immediately: state IDLE, `tcnt` 0, `pending` 0, `overflow` 0. As a result, `led` = 0 and `busy` = 0 at once.
  - Reset during ON forces `led` low without a gap.
  - Requests asserted during reset are lost.

## Timing
- A req sampled at the rising edge ending cycle n, with the block in IDLE and `pending` = 0:
  - `pending` = 1 in cycle n+1.
  - State = ON and `led` = 1 in cycle n+2.
- On-time: the edge that samples the ON_TICKS-th tick seen in ON moves the state to GAP, and `led` falls in the following cycle. Because ticks are not aligned to the pulse start, the on-time lies between ON_TICKS−1 and ON_TICKS tick periods plus one clk.
- The gap has the same tick-alignment bounds, using OFF_TICKS.
- Back-to-back pulses: GAP→IDLE, then IDLE→ON one cycle later if `pending` ≠ 0. IDLE therefore lasts exactly one clk between queued pulses.
- `pending`, `overflow` and state all update on the same rising edge. `overflow` is never high for two consecutive cycles unless dropped requests occur on consecutive cycles.
- With `tick` tied high (every cycle), ON lasts exactly ON_TICKS clk and GAP lasts exactly OFF_TICKS clk.

## Test plan
1. Reset, with defaults and `tick` every 10 clk: issue one req, then raise `rst_async` asynchronously mid-ON → `led`, `busy` and `pending` go to 0 immediately. After release, the block stays IDLE with no further pulse.
2. Single req, ON_TICKS=4, OFF_TICKS=4, `tick` every 10 clk:
   - `led` = 1 exactly 2 clk after req.
   - `led` falls 1 clk after the 4th tick in ON.
   - `busy` falls 1 clk after the 4th tick in GAP.
   - `overflow` never asserts.
3. Three reqs on consecutive cycles:
   - `pending` peaks at 2 (the first request has already been dequeued).
   - Exactly three `led` pulses, each followed by a full gap.
   - One IDLE clk between each gap and the next pulse.
4. Overflow with PEND_W=3: issue 1 req, then 8 reqs during its ON state:
   - `pending` saturates at 7.
   - `overflow` is high for exactly 1 clk, following the 8th of those reqs.
   - A total of 8 pulses result.
5. Simultaneous req and dequeue: reach IDLE with `pending` = 7 after a gap, and assert req on the dequeue cycle → `pending` stays 7 and `overflow` stays 0.
6. `tick` tied high, ON_TICKS=1, OFF_TICKS=2, one req → `led` high for exactly 1 clk, low for 2 clk of GAP, then IDLE.
